// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: response-state enum,
// port index type, default depth/index width and the address-check helper.
package imem_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_IDX_W = $clog2(IMEM_DEPTH);

    typedef logic port_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP0 = 2'd1,
        RESP1 = 2'd2
    } resp_state_t;

    // Misaligned or beyond the last word of a depth-word memory.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; last_gnt remembers the most recent winner.
module rr_arbiter2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    port_idx_t last_gnt_r;

    // Grant decision: a lone requester always wins, contention goes to the port not last served
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_gnt_r == 1'b1) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
        end
    end

    // Last-winner register, updated on every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_r <= 1'b1;
        end else if (gnt0) begin
            last_gnt_r <= 1'b0;
        end else if (gnt1) begin
            last_gnt_r <= 1'b1;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational-read instruction memory between two read ports.
// Optional IMEM_ARB_ERR_EN adds misaligned/out-of-range error responses.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [31:0]      addr0_i,
    input  logic [31:0]      addr1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             rvalid0_o,
    output logic             rvalid1_o,
    output logic [WIDTH-1:0] rdata0_o,
    output logic [WIDTH-1:0] rdata1_o,
    output logic             err0_o,
    output logic             err1_o,
    output logic [31:0]      mem_a_o,
    input  logic [WIDTH-1:0] mem_rd_i
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("imem_arbiter: DEPTH must be a power of two");
    end

    logic             gnt0_s;
    logic             gnt1_s;
    logic [31:0]      mem_a_s;
    logic [31:0]      mem_a_r;
    logic             bad_s;
    resp_state_t      state_r;
    resp_state_t      state_nxt_s;
    logic [WIDTH-1:0] rdata0_r;
    logic [WIDTH-1:0] rdata1_r;
    logic             err0_r;
    logic             err1_r;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req0  (req0_i),
        .req1  (req1_i),
        .gnt0  (gnt0_s),
        .gnt1  (gnt1_s)
    );

    assign gnt0_o = gnt0_s;
    assign gnt1_o = gnt1_s;

    // Memory address mux; holds the previous address while idle so the bus does not toggle
    always_comb begin
        mem_a_s = mem_a_r;
        if (gnt0_s) begin
            mem_a_s = addr0_i;
        end else if (gnt1_s) begin
            mem_a_s = addr1_i;
        end else begin
            mem_a_s = mem_a_r;
        end
    end

    assign mem_a_o = mem_a_s;

`ifdef IMEM_ARB_ERR_EN
    assign bad_s = addr_bad(mem_a_s, DEPTH);
`else
    assign bad_s = 1'b0;
`endif

    // Address hold register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_a_r <= 32'h0000_0000;
        end else begin
            mem_a_r <= mem_a_s;
        end
    end

    // Response state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state depends only on this cycle's grant, whatever the current state
    always_comb begin
        state_nxt_s = IDLE;
        if (gnt0_s) begin
            state_nxt_s = RESP0;
        end else if (gnt1_s) begin
            state_nxt_s = RESP1;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // Response-valid decode from the state register
    always_comb begin
        rvalid0_o = 1'b0;
        rvalid1_o = 1'b0;
        case (state_r)
            RESP0:   rvalid0_o = 1'b1;
            RESP1:   rvalid1_o = 1'b1;
            IDLE:    rvalid0_o = 1'b0;
            default: rvalid0_o = 1'b0;
        endcase
    end

    // Per-port response capture; an erroneous access returns zero data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
            err0_r   <= 1'b0;
            err1_r   <= 1'b0;
        end else begin
            err0_r <= gnt0_s & bad_s;
            err1_r <= gnt1_s & bad_s;
            if (gnt0_s) begin
                rdata0_r <= bad_s ? '0 : mem_rd_i;
            end else if (gnt1_s) begin
                rdata1_r <= bad_s ? '0 : mem_rd_i;
            end else begin
                rdata0_r <= rdata0_r;
            end
        end
    end

    assign rdata0_o = rdata0_r;
    assign rdata1_o = rdata1_r;
    assign err0_o   = err0_r;
    assign err1_o   = err1_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: memory model word i = 0x1000_0000 + i, scoreboard
// compare on every falling edge plus directed literal checks.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1, mem_a, mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rd = 32'h1000_0000 + {24'd0, mem_a[9:2]};

    imem_arbiter #(.WIDTH(32), .DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .req0_i(req0), .req1_i(req1), .addr0_i(addr0), .addr1_i(addr1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .err0_o(err0), .err1_o(err1),
        .mem_a_o(mem_a), .mem_rd_i(mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_bad(input logic [31:0] a);
`ifdef IMEM_ARB_ERR_EN
        return (a % 32'd4 != 32'd0) || (a / 32'd4 >= 32'd256);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard state: who won last, what response is owed next cycle
    int          m_last = 1;
    bit          m_pv = 1'b0;
    int          m_pport = 0;
    logic [31:0] m_pdata = 32'd0;
    bit          m_perr = 1'b0;
    logic [31:0] m_rd0 = 32'd0, m_rd1 = 32'd0, m_mema = 32'd0;

    always @(negedge clk) begin
        bit eg0, eg1;
        logic [31:0] a;
        if (reset) begin
            chk("rst_rvalid0", rvalid0, 1'b0);
            chk("rst_rvalid1", rvalid1, 1'b0);
            chk("rst_rdata0", rdata0, 32'd0);
            chk("rst_rdata1", rdata1, 32'd0);
            chk("rst_err", {err1, err0}, 2'b00);
            m_last = 1; m_pv = 1'b0; m_rd0 = 32'd0; m_rd1 = 32'd0; m_mema = 32'd0;
        end else begin
            if (m_pv && m_pport == 0) m_rd0 = m_pdata;
            if (m_pv && m_pport == 1) m_rd1 = m_pdata;
            chk("rvalid0", rvalid0, m_pv && m_pport == 0);
            chk("rvalid1", rvalid1, m_pv && m_pport == 1);
            chk("rdata0", rdata0, m_rd0);
            chk("rdata1", rdata1, m_rd1);
            chk("err0", err0, m_pv && m_pport == 0 && m_perr);
            chk("err1", err1, m_pv && m_pport == 1 && m_perr);
            eg0 = req0 && (!req1 || m_last == 1);
            eg1 = req1 && !eg0;
            chk("gnt0", gnt0, eg0);
            chk("gnt1", gnt1, eg1);
            if (eg0 || eg1) begin
                a       = eg0 ? addr0 : addr1;
                m_mema  = a;
                m_last  = eg1 ? 1 : 0;
                m_pv    = 1'b1;
                m_pport = eg1 ? 1 : 0;
                m_perr  = m_bad(a);
                m_pdata = m_perr ? 32'd0 : 32'h1000_0000 + ((a / 32'd4) % 32'd256);
            end else begin
                m_pv = 1'b0;
            end
            chk("mem_a", mem_a, m_mema);
        end
    end

    // Apply one cycle of requests; returns just after the capturing edge
    task automatic step(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = 32'd0; addr1 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_rvalid0", rvalid0, 1'b0);
        chk("lit_reset_mem_a", mem_a, 32'd0);
        reset = 1'b0;

        step(1'b1, 32'h10, 1'b0, 32'd0);
        chk("lit_first_rvalid0", rvalid0, 1'b1);
        chk("lit_first_rdata0", rdata0, 32'h1000_0004);
        chk("lit_first_rvalid1", rvalid1, 1'b0);

        // Serve port 1 once so the contention run starts with port 0
        step(1'b0, 32'd0, 1'b1, 32'h4);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0, 1'b1, 32'h4);
            chk("lit_alt_rvalid0", rvalid0, (i % 2) == 0);
            chk("lit_alt_rvalid1", rvalid1, (i % 2) == 1);
            if (i % 2 == 0) chk("lit_alt_rdata0", rdata0, 32'h1000_0000);
            else            chk("lit_alt_rdata1", rdata1, 32'h1000_0001);
        end

        step(1'b0, 32'd0, 1'b1, 32'h8);
        chk("lit_p1_rdata1", rdata1, 32'h1000_0002);
        step(1'b1, 32'hC, 1'b0, 32'd0);
        chk("lit_p0_rdata0", rdata0, 32'h1000_0003);
        chk("lit_p1_hold", rdata1, 32'h1000_0002);
        step(1'b0, 32'd0, 1'b0, 32'd0);
        chk("lit_mem_a_hold", mem_a, 32'hC);

        // Reset during a response
        step(1'b1, 32'h14, 1'b0, 32'd0);
        chk("lit_pre_rst_rvalid0", rvalid0, 1'b1);
        req0 = 1'b0;
        reset = 1'b1;
        #1;
        chk("lit_rst_mid_rvalid0", rvalid0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 32'h20, 1'b1, 32'h24);
        chk("lit_post_rst_rvalid0", rvalid0, 1'b1);
        chk("lit_post_rst_rdata0", rdata0, 32'h1000_0008);

        step(1'b1, 32'h400, 1'b0, 32'd0);
`ifdef IMEM_ARB_ERR_EN
        chk("lit_oor_err0", err0, 1'b1);
        chk("lit_oor_rdata0", rdata0, 32'd0);
`else
        chk("lit_wrap_err0", err0, 1'b0);
        chk("lit_wrap_rdata0", rdata0, 32'h1000_0000);
`endif
        step(1'b1, 32'h2, 1'b0, 32'd0);
`ifdef IMEM_ARB_ERR_EN
        chk("lit_mis_err0", err0, 1'b1);
        chk("lit_mis_rdata0", rdata0, 32'd0);
`else
        chk("lit_mis_err0", err0, 1'b0);
        chk("lit_mis_rdata0", rdata0, 32'h1000_0000);
`endif
        step(1'b0, 32'd0, 1'b1, 32'h3FF);
        chk("lit_p1_misc_rvalid1", rvalid1, 1'b1);

        // Mixed traffic, checked by the scoreboard
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(1)), $urandom_range(32'h7FF),
                 1'($urandom_range(1)), $urandom_range(32'h7FF));
        end
        step(1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
